// File: rtl/baud_rate_gen_frac.sv
// UART baud tick generator with runtime-loadable integer/fractional divisor.
// Emits an oversample tick and a bit tick every OVERSAMPLE oversample ticks.
module baud_rate_gen_frac #(
    parameter int DIV_BITS     = 16,
    parameter int FRAC_BITS    = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int OS_BITS      = 4,
    parameter int DEF_DIV_INT  = 13,
    parameter int DEF_DIV_FRAC = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_BITS-1:0]  div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    input  logic                 div_load,
    input  logic                 sync_clr,
    output logic                 tick,
    output logic                 bit_tick,
    output logic                 cfg_err
);

    logic [DIV_BITS-1:0]  cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic                 extra_q, extra_d;
    logic [OS_BITS-1:0]   os_q, os_d;
    logic [DIV_BITS-1:0]  act_int_q, act_int_d;
    logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;
    logic [DIV_BITS-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_BITS-1:0] sh_frac_q, sh_frac_d;
    logic                 pend_q, pend_d;
    logic                 tick_q, tick_d;
    logic                 bit_q, bit_d;
    logic                 err_q, err_d;

    logic [DIV_BITS:0]    period;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 term;
    logic                 load_bad;
    logic                 load_ok;

    // extra stretches one period by a clock whenever the accumulator carries
    assign period   = {1'b0, act_int_q} + {{DIV_BITS{1'b0}}, extra_q};
    assign term     = ({1'b0, cnt_q} == (period - (DIV_BITS+1)'(1)));
    assign acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
    assign load_bad = div_load & (div_int == '0);
    assign load_ok  = div_load & ~load_bad;

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        extra_d    = extra_q;
        os_d       = os_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        bit_d      = 1'b0;
        err_d      = load_bad;

        if (sync_clr) begin
            cnt_d   = '0;
            acc_d   = '0;
            extra_d = 1'b0;
            os_d    = '0;
            if (pend_q) begin
                act_int_d  = sh_int_q;
                act_frac_d = sh_frac_q;
                pend_d     = 1'b0;
            end
        end else if (enable) begin
            if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (os_q == OS_BITS'(OVERSAMPLE-1)) begin
                    os_d  = '0;
                    bit_d = 1'b1;
                end else begin
                    os_d = os_q + OS_BITS'(1);
                end
                if (pend_q) begin
                    act_int_d  = sh_int_q;
                    act_frac_d = sh_frac_q;
                    acc_d      = '0;
                    extra_d    = 1'b0;
                    pend_d     = 1'b0;
                end else begin
                    acc_d   = acc_sum[FRAC_BITS-1:0];
                    extra_d = acc_sum[FRAC_BITS];
                end
            end else begin
                cnt_d = cnt_q + DIV_BITS'(1);
            end
        end

        // capture runs after terminal handling so a load on a terminal waits a period
        if (load_ok) begin
            sh_int_d  = div_int;
            sh_frac_d = div_frac;
            if (enable) begin
                pend_d = 1'b1;
            end else begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
                cnt_d      = '0;
                acc_d      = '0;
                extra_d    = 1'b0;
                pend_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            extra_q    <= 1'b0;
            os_q       <= '0;
            act_int_q  <= DIV_BITS'(DEF_DIV_INT);
            act_frac_q <= FRAC_BITS'(DEF_DIV_FRAC);
            sh_int_q   <= DIV_BITS'(DEF_DIV_INT);
            sh_frac_q  <= FRAC_BITS'(DEF_DIV_FRAC);
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            bit_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            extra_q    <= extra_d;
            os_q       <= os_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
        end
    end

    assign tick     = tick_q;
    assign bit_tick = bit_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Bench for baud_rate_gen_frac: expected tick/bit/err cycles are queued
// as stimulus is driven and matched against DUT output on the falling edge.
module tb_baud_rate_gen_frac;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        sync_clr = 1'b0;
    logic        tick;
    logic        bit_tick;
    logic        cfg_err;

    baud_rate_gen_frac dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .sync_clr (sync_clr),
        .tick     (tick),
        .bit_tick (bit_tick),
        .cfg_err  (cfg_err)
    );

    always #5 clock = ~clock;

    int abs_c = 0;
    int base_c = 0;
    always @(posedge clock) abs_c <= abs_c + 1;

    function automatic int cyc();
        return abs_c - base_c;
    endfunction

    int n_vec = 0;
    int n_miss = 0;
    int exp_t[$];
    int exp_b[$];
    int exp_e[$];
    int seen_q[$];

    function automatic void chk(string nm, int act, int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp_v, cyc());
        end
    endfunction

    // scoreboard: every output pulse must match the head of its queue
    always @(negedge clock) begin
        if (reset) begin
            if (tick) begin
                seen_q.push_back(cyc());
                if (exp_t.size() == 0) chk("tick_extra", cyc(), -1);
                else chk("tick_cycle", cyc(), exp_t.pop_front());
            end
            if (bit_tick) begin
                if (exp_b.size() == 0) chk("bit_extra", cyc(), -1);
                else chk("bit_cycle", cyc(), exp_b.pop_front());
            end
            if (cfg_err) begin
                if (exp_e.size() == 0) chk("err_extra", cyc(), -1);
                else chk("err_cycle", cyc(), exp_e.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc() < c) @(negedge clock);
    endtask

    task automatic drain(input string nm);
        chk({nm, "_missing"}, exp_t.size() + exp_b.size() + exp_e.size(), 0);
        exp_t.delete();
        exp_b.delete();
        exp_e.delete();
    endtask

    // leaves the bench on the release negedge, which is cycle 0
    task automatic do_reset(input logic en);
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b0;
        div_load = 1'b0;
        sync_clr = 1'b0;
        div_int = '0;
        div_frac = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        enable = en;
        base_c = abs_c;
        seen_q.delete();
    endtask

    task automatic load_and_run(input int di, input int df);
        div_load = 1'b1;
        div_int = 16'(di);
        div_frac = 4'(df);
        @(negedge clock);
        div_load = 1'b0;
        enable = 1'b1;
    endtask

    typedef struct {
        int di;
        int df;
        int span;
    } vec_t;
    vec_t vt[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{13, 9, 217};
        vt[1] = '{4, 0, 64};
        vt[2] = '{1, 0, 16};
        vt[3] = '{2, 8, 40};
        vt[4] = '{3, 15, 63};
        vt[5] = '{1, 15, 31};
        vt[6] = '{7, 1, 113};

        // defaults from reset, then mid-period reload and a rejected load
        repeat (2) @(negedge clock);
        chk("rst_tick", int'(tick), 0);
        chk("rst_bit", int'(bit_tick), 0);
        chk("rst_err", int'(cfg_err), 0);
        enable = 1'b1;
        reset = 1'b1;
        base_c = abs_c;
        for (int k = 0; k < 32; k++) exp_t.push_back(13 * (k + 1) + (9 * k) / 16);
        exp_b.push_back(216);
        exp_b.push_back(433);
        wait_cyc(440);
        drain("defaults");
        div_load = 1'b1;
        div_int = 16'd4;
        div_frac = 4'd0;
        exp_t.push_back(447);
        for (int j = 0; j < 28; j++) exp_t.push_back(451 + 4 * j);
        exp_b.push_back(507);
        @(negedge clock);
        div_load = 1'b0;
        wait_cyc(520);
        div_load = 1'b1;
        div_int = 16'd0;
        div_frac = 4'd5;
        exp_e.push_back(521);
        @(negedge clock);
        div_load = 1'b0;
        wait_cyc(560);
        enable = 1'b0;
        wait_cyc(566);
        drain("reload");

        // enable dropped for 7 cycles with cnt=5, divisor 10
        do_reset(1'b0);
        load_and_run(10, 0);
        exp_t = '{11, 21, 31, 48, 58, 68};
        wait_cyc(36);
        enable = 1'b0;
        wait_cyc(43);
        enable = 1'b1;
        wait_cyc(70);
        enable = 1'b0;
        wait_cyc(75);
        drain("enable_hold");

        // sync_clr at os_cnt=9, cnt=6, divisor 13/0
        do_reset(1'b0);
        load_and_run(13, 0);
        for (int k = 0; k < 9; k++) exp_t.push_back(14 + 13 * k);
        for (int k = 0; k < 16; k++) exp_t.push_back(138 + 13 * k);
        exp_b.push_back(333);
        wait_cyc(124);
        sync_clr = 1'b1;
        @(negedge clock);
        sync_clr = 1'b0;
        wait_cyc(335);
        enable = 1'b0;
        wait_cyc(340);
        drain("sync_clr");

        // load on a terminal waits a period; sync_clr applies a pending load
        do_reset(1'b0);
        load_and_run(10, 0);
        exp_t = '{11, 21, 31, 36, 41, 46, 52, 55, 58};
        wait_cyc(20);
        div_load = 1'b1;
        div_int = 16'd5;
        @(negedge clock);
        div_load = 1'b0;
        wait_cyc(47);
        div_load = 1'b1;
        div_int = 16'd3;
        @(negedge clock);
        div_load = 1'b0;
        sync_clr = 1'b1;
        @(negedge clock);
        sync_clr = 1'b0;
        wait_cyc(59);
        enable = 1'b0;
        wait_cyc(64);
        drain("pending");

        // reset asserted while a tick is high, divisor 2/8
        do_reset(1'b0);
        load_and_run(2, 8);
        exp_t.push_back(3);
        wait_cyc(4);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_bit", int'(bit_tick), 0);
        chk("midrst_err", int'(cfg_err), 0);
        drain("pre_midrst");
        @(negedge clock);
        reset = 1'b1;
        base_c = abs_c;
        exp_t = '{13, 26, 40};
        wait_cyc(41);
        enable = 1'b0;
        wait_cyc(45);
        drain("post_midrst");

        // table: 17 ticks per divisor, 16-tick span must be exact
        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0);
            load_and_run(vt[i].di, vt[i].df);
            for (int k = 0; k < 17; k++)
                exp_t.push_back(1 + vt[i].di * (k + 1) + (vt[i].df * k) / 16);
            exp_b.push_back(1 + vt[i].di * 16 + (vt[i].df * 15) / 16);
            wait_cyc(1 + 17 * vt[i].di + vt[i].df);
            enable = 1'b0;
            wait_cyc(4 + 17 * vt[i].di + vt[i].df);
            drain($sformatf("vec%0d", i));
            if (seen_q.size() >= 17)
                chk($sformatf("vec%0d_span", i), seen_q[16] - seen_q[0], vt[i].span);
            else
                chk($sformatf("vec%0d_count", i), seen_q.size(), 17);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
